// File: rtl/fpu_iter_rnd.sv
// rtl/fpu_iter_rnd.sv - iterative IEEE-style add/sub/mul/div FPU with rounding modes
// Operands flow IDLE->UNPACK->(SPECIAL|ALIGN->ADDSUB|MULDIV)->NORM->ROUND->DONE under valid/ready.
`timescale 1ns/1ps
module fpu_iter_rnd #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [1:0]   op,
  input  logic [1:0]   rm,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic [4:0]   flags
);
  localparam int M    = MAN_W + 1;
  localparam int EW   = MAN_W + 4;
  localparam int MW   = MAN_W + 5;
  localparam int XW   = EXP_W + 2;
  localparam int CW   = $clog2(M + 2) + 1;
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int EMAX = (1 << EXP_W) - 1;
  localparam logic [1:0] OP_SUB = 2'b01, OP_MUL = 2'b10;
  localparam logic [1:0] RM_RNE = 2'b00, RM_RTZ = 2'b01, RM_RUP = 2'b10, RM_RDN = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE, S_UNPACK, S_SPECIAL, S_ALIGN, S_ADDSUB, S_MULDIV, S_NORM, S_ROUND, S_DONE
  } state_t;
  state_t r_state, w_next;

  logic [W-1:0]          r_a, r_b, r_result;
  logic [1:0]            r_op, r_rm;
  logic [4:0]            r_flags;
  logic                  r_sa, r_sb, r_sub, r_sign;
  logic [EXP_W-1:0]      r_ea, r_eb;
  logic [M-1:0]          r_ma, r_mb;
  logic [EW-1:0]         r_x, r_y;
  logic signed [XW-1:0]  r_exp;
  logic [MW-1:0]         r_man;
  logic [2*M-1:0]        r_prod, r_mcand;
  logic [M:0]            r_rem, r_q;
  logic [CW-1:0]         r_cnt;

  function automatic logic [W-1:0] f_inf(input logic s);
    return {s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
  endfunction
  function automatic logic [W-1:0] f_zero(input logic s);
    return {s, {(W-1){1'b0}}};
  endfunction
  function automatic logic [W-1:0] f_max(input logic s);
    return {s, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
  endfunction

  // Operand classification; subnormals are treated as zeros (flushed)
  logic [EXP_W-1:0] w_ea_f, w_eb_f, w_ea, w_eb;
  logic [MAN_W-1:0] w_fa, w_fb;
  logic [M-1:0]     w_ma, w_mb;
  logic w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan, w_a_snan, w_b_snan;
  logic w_sa, w_sb, w_sm;
  assign w_ea_f   = r_a[W-2:MAN_W];
  assign w_eb_f   = r_b[W-2:MAN_W];
  assign w_fa     = r_a[MAN_W-1:0];
  assign w_fb     = r_b[MAN_W-1:0];
  assign w_a_zero = ~|w_ea_f;
  assign w_b_zero = ~|w_eb_f;
  assign w_a_nan  = (&w_ea_f) & (|w_fa);
  assign w_b_nan  = (&w_eb_f) & (|w_fb);
  assign w_a_inf  = (&w_ea_f) & ~(|w_fa);
  assign w_b_inf  = (&w_eb_f) & ~(|w_fb);
  assign w_a_snan = w_a_nan & ~w_fa[MAN_W-1];
  assign w_b_snan = w_b_nan & ~w_fb[MAN_W-1];
  assign w_sa     = r_a[W-1];
  assign w_sb     = r_b[W-1] ^ (r_op == OP_SUB);
  assign w_sm     = r_a[W-1] ^ r_b[W-1];
  assign w_ma     = w_a_zero ? '0 : {1'b1, w_fa};
  assign w_mb     = w_b_zero ? '0 : {1'b1, w_fb};
  assign w_ea     = w_a_zero ? '0 : w_ea_f;
  assign w_eb     = w_b_zero ? '0 : w_eb_f;

  logic         w_special;
  logic [W-1:0] w_spec_res;
  logic [4:0]   w_spec_flags;
  always_comb begin
    w_special    = 1'b1;
    w_spec_res   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    w_spec_flags = 5'b00000;
    if (w_a_nan | w_b_nan) begin
      w_spec_flags[4] = w_a_snan | w_b_snan;
    end else if (!r_op[1]) begin
      if (w_a_inf & w_b_inf & (w_sa ^ w_sb)) w_spec_flags[4] = 1'b1;
      else if (w_a_inf)                      w_spec_res = f_inf(w_sa);
      else if (w_b_inf)                      w_spec_res = f_inf(w_sb);
      else if (w_a_zero & w_b_zero)
        w_spec_res = f_zero((w_sa & w_sb) | ((r_rm == RM_RDN) & (w_sa | w_sb)));
      else                                   w_special = 1'b0;
    end else if (r_op == OP_MUL) begin
      if ((w_a_inf & w_b_zero) | (w_a_zero & w_b_inf)) w_spec_flags[4] = 1'b1;
      else if (w_a_inf | w_b_inf)                      w_spec_res = f_inf(w_sm);
      else if (w_a_zero | w_b_zero)                    w_spec_res = f_zero(w_sm);
      else                                             w_special = 1'b0;
    end else begin
      if ((w_a_zero & w_b_zero) | (w_a_inf & w_b_inf)) w_spec_flags[4] = 1'b1;
      else if (w_a_inf)  w_spec_res = f_inf(w_sm);
      else if (w_b_inf)  w_spec_res = f_zero(w_sm);
      else if (w_b_zero) begin
        w_spec_res      = f_inf(w_sm);
        w_spec_flags[3] = 1'b1;
      end
      else if (w_a_zero) w_spec_res = f_zero(w_sm);
      else               w_special = 1'b0;
    end
  end

  // Alignment: larger magnitude becomes X, smaller is shifted right with sticky collection
  logic             w_swap, w_sl;
  logic [EXP_W-1:0] w_el, w_es, w_diff;
  logic [M-1:0]     w_ml, w_ms;
  logic [EW-1:0]    w_ext_s, w_y;
  logic [MW-1:0]    w_sum;
  always_comb begin
    w_swap  = {r_eb, r_mb} > {r_ea, r_ma};
    w_el    = w_swap ? r_eb : r_ea;
    w_es    = w_swap ? r_ea : r_eb;
    w_ml    = w_swap ? r_mb : r_ma;
    w_ms    = w_swap ? r_ma : r_mb;
    w_sl    = w_swap ? r_sb : r_sa;
    w_diff  = w_el - w_es;
    w_ext_s = {w_ms, 3'b000};
    if (w_diff > EXP_W'(MAN_W + 3))
      w_y = {{(EW-1){1'b0}}, |w_ms};
    else
      w_y = (w_ext_s >> w_diff) |
            {{(EW-1){1'b0}}, |(w_ext_s & ~({EW{1'b1}} << w_diff))};
  end
  assign w_sum = r_sub ? ({1'b0, r_x} - {1'b0, r_y}) : ({1'b0, r_x} + {1'b0, r_y});

  logic [2*M-1:0] w_prod_n;
  logic           w_ge, w_md_last;
  logic [M:0]     w_rem_d;
  logic [M+1:0]   w_q_n;
  assign w_prod_n  = r_prod + (r_mb[0] ? r_mcand : '0);
  assign w_ge      = r_rem >= {1'b0, r_mb};
  assign w_rem_d   = w_ge ? (r_rem - {1'b0, r_mb}) : r_rem;
  assign w_q_n     = {r_q, w_ge};
  assign w_md_last = r_op[0] ? (r_cnt == CW'(M + 1)) : (r_cnt == CW'(M - 1));

  // Rounding: mantissa is {carry, hidden, fraction, G, R, S}
  logic                 w_inc, w_gs, w_uf, w_of;
  logic [M:0]           w_mr;
  logic [MAN_W-1:0]     w_frac_r;
  logic signed [XW-1:0] w_exp_r;
  logic [W-1:0]         w_rnd_res;
  logic [4:0]           w_rnd_flags;
  assign w_gs = |r_man[2:0];
  always_comb begin
    case (r_rm)
      RM_RNE:  w_inc = r_man[2] & (r_man[1] | r_man[0] | r_man[3]);
      RM_RTZ:  w_inc = 1'b0;
      RM_RUP:  w_inc = ~r_sign & w_gs;
      default: w_inc = r_sign & w_gs;
    endcase
  end
  assign w_mr     = {1'b0, r_man[MW-2:3]} + (M+1)'(w_inc);
  assign w_frac_r = w_mr[M] ? w_mr[MAN_W:1] : w_mr[MAN_W-1:0];
  assign w_exp_r  = r_exp + XW'(w_mr[M]);
  assign w_uf     = w_exp_r[XW-1] | (w_exp_r == '0);
  assign w_of     = ~w_exp_r[XW-1] & (w_exp_r[XW-2:0] >= (XW-1)'(EMAX));
  always_comb begin
    w_rnd_res   = {r_sign, w_exp_r[EXP_W-1:0], w_frac_r};
    w_rnd_flags = {4'b0000, w_gs};
    if (r_man == '0) begin
      w_rnd_res   = f_zero(r_sign);
      w_rnd_flags = 5'b00000;
    end else if (w_of) begin
      w_rnd_flags = 5'b00101;
      case (r_rm)
        RM_RNE:  w_rnd_res = f_inf(r_sign);
        RM_RTZ:  w_rnd_res = f_max(r_sign);
        RM_RUP:  w_rnd_res = r_sign ? f_max(1'b1) : f_inf(1'b0);
        default: w_rnd_res = r_sign ? f_inf(1'b1) : f_max(1'b0);
      endcase
    end else if (w_uf) begin
      w_rnd_res   = f_zero(r_sign);
      w_rnd_flags = 5'b00011;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (in_valid) w_next = S_UNPACK;
      S_UNPACK:  w_next = w_special ? S_SPECIAL : (r_op[1] ? S_MULDIV : S_ALIGN);
      S_SPECIAL: w_next = S_DONE;
      S_ALIGN:   w_next = S_ADDSUB;
      S_ADDSUB:  w_next = S_NORM;
      S_MULDIV:  if (w_md_last) w_next = S_NORM;
      S_NORM:    if (!r_man[MW-1] && (r_man[MW-2] || r_man == '0)) w_next = S_ROUND;
      S_ROUND:   w_next = S_DONE;
      S_DONE:    if (out_ready) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a <= '0; r_b <= '0; r_op <= '0; r_rm <= '0; r_result <= '0; r_flags <= '0;
      r_sa <= 1'b0; r_sb <= 1'b0; r_sub <= 1'b0; r_sign <= 1'b0;
      r_ea <= '0; r_eb <= '0; r_ma <= '0; r_mb <= '0; r_x <= '0; r_y <= '0;
      r_exp <= '0; r_man <= '0; r_prod <= '0; r_mcand <= '0; r_rem <= '0; r_q <= '0;
      r_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_a <= a; r_b <= b; r_op <= op; r_rm <= rm;
        end
        S_UNPACK: begin
          r_sa <= w_sa; r_sb <= w_sb; r_ea <= w_ea; r_eb <= w_eb;
          r_ma <= w_ma; r_mb <= w_mb; r_sign <= w_sm;
          r_mcand <= {{M{1'b0}}, w_ma};
          r_prod <= '0; r_rem <= {1'b0, w_ma}; r_q <= '0; r_cnt <= '0;
          r_exp <= r_op[0] ? XW'(w_ea) - XW'(w_eb) + XW'(BIAS)
                           : XW'(w_ea) + XW'(w_eb) - XW'(BIAS);
          if (w_special) begin
            r_result <= w_spec_res;
            r_flags  <= w_spec_flags;
          end
        end
        S_ALIGN: begin
          r_x <= {w_ml, 3'b000}; r_y <= w_y;
          r_exp <= XW'(w_el); r_sign <= w_sl; r_sub <= r_sa ^ r_sb;
        end
        S_ADDSUB: begin
          r_man <= w_sum;
          if (w_sum == '0) r_sign <= (r_rm == RM_RDN);
        end
        S_MULDIV: begin
          r_cnt <= r_cnt + 1'b1;
          if (!r_op[0]) begin
            r_prod  <= w_prod_n;
            r_mcand <= r_mcand << 1;
            r_mb    <= r_mb >> 1;
            if (w_md_last) r_man <= {w_prod_n[2*M-1:M-3], |w_prod_n[M-4:0]};
          end else begin
            r_rem <= w_rem_d << 1;
            r_q   <= w_q_n[M:0];
            if (w_md_last) r_man <= {1'b0, w_q_n, |w_rem_d};
          end
        end
        S_NORM: begin
          if (r_man[MW-1]) begin
            r_man <= {1'b0, r_man[MW-1:2], r_man[1] | r_man[0]};
            r_exp <= r_exp + XW'(1);
          end else if (!r_man[MW-2] && r_man != '0) begin
            r_man <= {r_man[MW-2:1], 1'b0, r_man[0]};
            r_exp <= r_exp - XW'(1);
          end
        end
        S_ROUND: begin
          r_result <= w_rnd_res;
          r_flags  <= w_rnd_flags;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign result    = r_result;
  assign flags     = r_flags;
endmodule
